// File: rtl/memtest_ddr_pkg.sv
// Shared types and pattern generator for the DDR3 memory tester.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package memtest_ddr_pkg;

  // Salt mixed into every pattern word so that pass 0 is not all-zero
  localparam logic [15:0] PATTERN_SALT = 16'hA5C3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_DATA = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] PHASE_IDLE  = 2'd0;
  localparam logic [1:0] PHASE_WRITE = 2'd1;
  localparam logic [1:0] PHASE_READ  = 2'd2;
  localparam logic [1:0] PHASE_DRAIN = 2'd3;

  // Word at region offset in a given pass: s in the upper half, ~s in the lower
  function automatic logic [63:0] pattern(input logic [31:0] offset, input logic [15:0] pass);
    logic [31:0] s;
    s = offset ^ {pass, PATTERN_SALT};
    return {s, ~s};
  endfunction

endpackage

// File: rtl/memtest_ddr_pattern.sv
// Maps a region offset and pass seed to the 64-bit test word.
// Latency: combinational.
// Backpressure: none.
module memtest_ddr_pattern
  import memtest_ddr_pkg::*;
(
  input  logic [31:0] offset,
  input  logic [15:0] pass,
  output logic [63:0] data
);

  assign data = pattern(offset, pass);

endmodule

// File: rtl/memtest_ddr_tester.sv
// DDR3 Avalon-MM tester: burst-fills a region with a pass-seeded pattern, reads it back, counts mismatches.
// Latency: read beats compared one cycle after DDRAM_DOUT_READY; passcount bumps in the DRAIN cycle.
// Backpressure: DDRAM_BUSY stalls write beats and read requests; read data is never stalled.
// Optional MEMTEST_DDR_ERRLOG_EN adds err_valid/err_addr/err_syndrome capture of the first mismatch.
module memtest_ddr_tester
  import memtest_ddr_pkg::*;
#(
  parameter logic [28:0] BASE_ADDR = 29'h0600_0000,
  parameter int          SIZE_LOG2 = 23,
  parameter int          BURST     = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ddram_busy,
  output logic [7:0]  ddram_burstcnt,
  output logic [28:0] ddram_addr,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_dout_ready,
  output logic        ddram_rd,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  output logic        ddram_we,
  output logic [31:0] passcount,
  output logic [31:0] failcount,
  output logic [1:0]  phase
`ifdef MEMTEST_DDR_ERRLOG_EN
  ,
  output logic        err_valid,
  output logic [28:0] err_addr,
  output logic [63:0] err_syndrome
`endif
);

  localparam int               OFF_W          = SIZE_LOG2;
  localparam logic [OFF_W-1:0] BURST_STEP     = OFF_W'(BURST);
  localparam logic [OFF_W-1:0] LAST_BURST_OFF = OFF_W'(2 ** SIZE_LOG2 - BURST);
  localparam logic [7:0]       BEAT_LAST      = 8'(BURST - 1);
  localparam logic [7:0]       BURST_CNT      = 8'(BURST);

  state_t           state;
  logic [OFF_W-1:0] burst_off;  // region offset of the current burst's first word
  logic [7:0]       beat_cnt;   // beat index within the current burst
  logic [OFF_W-1:0] beat_off;
  logic [31:0]      beat_off32;
  logic [63:0]      wr_word;
  logic [63:0]      rd_exp;

  logic             cmp_vld;
  logic [63:0]      cmp_dat;
  logic [63:0]      cmp_exp;
  logic             cmp_miss;

  assign beat_off   = burst_off + OFF_W'(beat_cnt);
  assign beat_off32 = 32'(beat_off);

  memtest_ddr_pattern u_wr_pattern (
    .offset (beat_off32),
    .pass   (passcount[15:0]),
    .data   (wr_word)
  );

  memtest_ddr_pattern u_rd_pattern (
    .offset (beat_off32),
    .pass   (passcount[15:0]),
    .data   (rd_exp)
  );

  // Bus outputs decode straight from state so an async reset clears them immediately;
  // command fields are only driven while a request is being presented.
  always_comb begin
    ddram_we       = (state == WR);
    ddram_rd       = (state == RD_REQ);
    ddram_din      = ddram_we ? wr_word : 64'd0;
    ddram_be       = ddram_we ? 8'hFF : 8'h00;
    ddram_addr     = (ddram_we || ddram_rd) ? (BASE_ADDR + 29'(burst_off)) : 29'd0;
    ddram_burstcnt = (ddram_we || ddram_rd) ? BURST_CNT : 8'd0;
    case (state)
      WR:             phase = PHASE_WRITE;
      RD_REQ, RD_DATA: phase = PHASE_READ;
      DRAIN:          phase = PHASE_DRAIN;
      default:        phase = PHASE_IDLE;
    endcase
  end

  // Pass sequencer: write all bursts, then one read burst at a time, then drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      burst_off <= '0;
      beat_cnt  <= 8'd0;
      passcount <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= WR;
            burst_off <= '0;
            beat_cnt  <= 8'd0;
          end
        end
        WR: begin
          if (!ddram_busy) begin
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= 8'd0;
              if (burst_off == LAST_BURST_OFF) begin
                burst_off <= '0;
                state     <= RD_REQ;
              end else begin
                burst_off <= burst_off + BURST_STEP;
              end
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        RD_REQ: begin
          if (!ddram_busy) begin
            state    <= RD_DATA;
            beat_cnt <= 8'd0;
          end
        end
        RD_DATA: begin
          if (ddram_dout_ready) begin
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= 8'd0;
              if (burst_off == LAST_BURST_OFF) begin
                burst_off <= '0;
                state     <= DRAIN;
              end else begin
                burst_off <= burst_off + BURST_STEP;
                state     <= RD_REQ;
              end
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        DRAIN: begin
          // The last read beat's compare retires on this same edge
          passcount <= passcount + 32'd1;
          burst_off <= '0;
          beat_cnt  <= 8'd0;
          state     <= enable ? WR : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register each read beat with its expected word; stray beats outside RD_DATA are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_vld <= 1'b0;
      cmp_dat <= 64'd0;
      cmp_exp <= 64'd0;
    end else begin
      cmp_vld <= (state == RD_DATA) && ddram_dout_ready;
      if ((state == RD_DATA) && ddram_dout_ready) begin
        cmp_dat <= ddram_dout;
        cmp_exp <= rd_exp;
      end
    end
  end

  assign cmp_miss = cmp_vld && (cmp_dat != cmp_exp);

  // Saturating mismatch counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      failcount <= 32'd0;
    end else if (cmp_miss && (failcount != 32'hFFFF_FFFF)) begin
      failcount <= failcount + 32'd1;
    end
  end

`ifdef MEMTEST_DDR_ERRLOG_EN
  logic [OFF_W-1:0] cmp_off;

  // Track the offset alongside the compare stage for the error log
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_off <= '0;
    end else if ((state == RD_DATA) && ddram_dout_ready) begin
      cmp_off <= beat_off;
    end
  end

  // Capture only the first mismatch since reset; later ones are just counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid    <= 1'b0;
      err_addr     <= 29'd0;
      err_syndrome <= 64'd0;
    end else if (cmp_miss && !err_valid) begin
      err_valid    <= 1'b1;
      err_addr     <= BASE_ADDR + 29'(cmp_off);
      err_syndrome <= cmp_dat ^ cmp_exp;
    end
  end
`endif

endmodule

// File: tb/tb_memtest_ddr_tester.sv
// Directed bench for memtest_ddr_tester with a small Avalon burst memory model.
// Latency: model returns read beats from the cycle after a read request is accepted.
// Backpressure: model busy is directed (counted cycles) or random per phase of the test.
module tb_memtest_ddr_tester;

  localparam logic [28:0] BASE  = 29'h0600_0000;
  localparam int          WORDS = 1024;
  localparam int          BL    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        ddram_busy;
  logic [7:0]  ddram_burstcnt;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic        ddram_rd;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_we;
  logic [31:0] passcount;
  logic [31:0] failcount;
  logic [1:0]  phase;
`ifdef MEMTEST_DDR_ERRLOG_EN
  logic        err_valid;
  logic [28:0] err_addr;
  logic [63:0] err_syndrome;
`endif

  int checks = 0;
  int errors = 0;

  // Memory model state
  logic [63:0] mem [0:WORDS-1];
  logic [28:0] waddr;
  int          wbeat     = 0;
  int          wr_total  = 0;
  int          burst_err = 0;
  int          rd_left   = 0;
  int          roff      = 0;
  int          busy_req  = 0;
  bit          rand_busy = 1'b0;
  bit          flip37    = 1'b0;
  bit          flip3     = 1'b0;

  always #5 clk = ~clk;

  memtest_ddr_tester #(
    .BASE_ADDR (BASE),
    .SIZE_LOG2 (10),
    .BURST     (BL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .ddram_busy       (ddram_busy),
    .ddram_burstcnt   (ddram_burstcnt),
    .ddram_addr       (ddram_addr),
    .ddram_dout       (ddram_dout),
    .ddram_dout_ready (ddram_dout_ready),
    .ddram_rd         (ddram_rd),
    .ddram_din        (ddram_din),
    .ddram_be         (ddram_be),
    .ddram_we         (ddram_we),
    .passcount        (passcount),
    .failcount        (failcount),
    .phase            (phase)
`ifdef MEMTEST_DDR_ERRLOG_EN
    ,
    .err_valid        (err_valid),
    .err_addr         (err_addr),
    .err_syndrome     (err_syndrome)
`endif
  );

  function automatic logic [63:0] flip_mask(input int off);
    if ((flip37 && off == 37) || (flip3 && (off == 100 || off == 500)))
      return 64'h20;
    return 64'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input logic [1:0] ph, input int limit);
    int n = 0;
    while (phase !== ph && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (phase === ph) else begin
      errors++;
      $error("FAIL wait_phase timeout: observed %0d expected %0d", phase, ph);
    end
  endtask

  // Avalon memory model: decides acceptance at negedge, drives busy/read data just after posedge
  initial begin
    ddram_busy       = 1'b0;
    ddram_dout_ready = 1'b0;
    ddram_dout       = 64'd0;
    waddr            = 29'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wbeat   = 0;
        rd_left = 0;
      end else begin
        if (ddram_we && !ddram_busy) begin
          if (wbeat == 0) waddr = ddram_addr;
          else if (ddram_addr != waddr) burst_err++;
          mem[int'(waddr - BASE) + wbeat] = ddram_din;
          wr_total++;
          wbeat = (wbeat + 1) % BL;
        end
        if (ddram_rd && !ddram_busy) begin
          if (rd_left != 0) burst_err++;
          rd_left = BL;
          roff    = int'(ddram_addr - BASE);
        end
      end
      @(posedge clk);
      #1;
      if (busy_req > 0) begin
        ddram_busy = 1'b1;
        busy_req--;
      end else begin
        ddram_busy = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (!reset && rd_left > 0 && (!rand_busy || $urandom_range(0, 2) != 0)) begin
        ddram_dout       = mem[roff] ^ flip_mask(roff);
        ddram_dout_ready = 1'b1;
        roff++;
        rd_left--;
      end else begin
        ddram_dout_ready = 1'b0;
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", 64'(ddram_we), 64'd0);
    check("rst_rd", 64'(ddram_rd), 64'd0);
    check("rst_addr", 64'(ddram_addr), 64'd0);
    check("rst_burstcnt", 64'(ddram_burstcnt), 64'd0);
    check("rst_din", ddram_din, 64'd0);
    check("rst_be", 64'(ddram_be), 64'd0);
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_pass", 64'(passcount), 64'd0);
    check("rst_fail", 64'(failcount), 64'd0);
`ifdef MEMTEST_DDR_ERRLOG_EN
    check("rst_err_valid", 64'(err_valid), 64'd0);
`endif

    // Pass 1: first write beat
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check("wr0_phase", 64'(phase), 64'd1);
    check("wr0_we", 64'(ddram_we), 64'd1);
    check("wr0_addr", 64'(ddram_addr), 64'(BASE));
    check("wr0_burstcnt", 64'(ddram_burstcnt), 64'd16);
    check("wr0_din", ddram_din, 64'h0000A5C3_FFFF5A3C);
    check("wr0_be", 64'(ddram_be), 64'hFF);

    // Busy for 3 cycles mid-burst: beat 6 must be held
    repeat (5) @(negedge clk);
    busy_req = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_hold_addr", 64'(ddram_addr), 64'(BASE));
      check("busy_hold_cnt", 64'(ddram_burstcnt), 64'd16);
      check("busy_hold_din", ddram_din, 64'h0000A5C5_FFFF5A3A);
    end

    // Pass 1 complete and clean
    wait_phase(2'd3, 6000);
    check("p1_mem0", mem[0], 64'h0000A5C3_FFFF5A3C);
    check("p1_mem37", mem[37], 64'h0000A5E6_FFFF5A19);
    check("p1_wr_total", 64'(wr_total), 64'd1024);
    check("p1_burst_err", 64'(burst_err), 64'd0);
    @(negedge clk);
    check("p1_pass", 64'(passcount), 64'd1);
    check("p1_fail", 64'(failcount), 64'd0);

    // Pass 2: one flipped bit, enable dropped during the read phase
    flip37 = 1'b1;
    wait_phase(2'd2, 3000);
    enable = 1'b0;
    wait_phase(2'd3, 3000);
    @(negedge clk);
    check("p2_pass", 64'(passcount), 64'd2);
    check("p2_fail", 64'(failcount), 64'd1);
    check("p2_phase", 64'(phase), 64'd0);
    check("p2_we", 64'(ddram_we), 64'd0);
    check("p2_rd", 64'(ddram_rd), 64'd0);
    check("p2_wr_total", 64'(wr_total), 64'd2048);
`ifdef MEMTEST_DDR_ERRLOG_EN
    check("p2_err_valid", 64'(err_valid), 64'd1);
    check("p2_err_addr", 64'(err_addr), 64'h0600_0025);
    check("p2_err_syn", err_syndrome, 64'h20);
`endif
    repeat (5) @(negedge clk);
    check("idle_phase", 64'(phase), 64'd0);
    check("idle_pass", 64'(passcount), 64'd2);

    // Pass 3: failcount preloaded near max, three mismatches, random busy
    enable = 1'b1;
    @(negedge clk);
    check("p3_phase", 64'(phase), 64'd1);
    force dut.failcount = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.failcount;
    @(negedge clk);
    check("p3_preload", 64'(failcount), 64'hFFFF_FFFE);
    flip3     = 1'b1;
    rand_busy = 1'b1;
    wait_phase(2'd3, 20000);
    @(negedge clk);
    check("p3_pass", 64'(passcount), 64'd3);
    check("p3_fail_sat", 64'(failcount), 64'hFFFF_FFFF);
    check("p3_burst_err", 64'(burst_err), 64'd0);
`ifdef MEMTEST_DDR_ERRLOG_EN
    check("p3_err_addr", 64'(err_addr), 64'h0600_0025);
`endif

    // Pass 4: reset in the middle of a read burst
    flip37    = 1'b0;
    flip3     = 1'b0;
    rand_busy = 1'b0;
    wait_phase(2'd2, 6000);
    repeat (40) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_we", 64'(ddram_we), 64'd0);
    check("mid_rst_rd", 64'(ddram_rd), 64'd0);
    check("mid_rst_addr", 64'(ddram_addr), 64'd0);
    check("mid_rst_burstcnt", 64'(ddram_burstcnt), 64'd0);
    check("mid_rst_be", 64'(ddram_be), 64'd0);
    check("mid_rst_phase", 64'(phase), 64'd0);
    check("mid_rst_pass", 64'(passcount), 64'd0);
    check("mid_rst_fail", 64'(failcount), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("restart_phase", 64'(phase), 64'd1);
    check("restart_addr", 64'(ddram_addr), 64'(BASE));
    check("restart_din", ddram_din, 64'h0000A5C3_FFFF5A3C);
    wait_phase(2'd3, 6000);
    @(negedge clk);
    check("restart_pass", 64'(passcount), 64'd1);
    check("restart_fail", 64'(failcount), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
